fetch_queue: RTL and testbench

Decoupling buffer between instruction fetch and decode. It accepts (pc, instruction) pairs from the fetch stage through a valid/ready enqueue port, and presents them in order to decode through a valid/ready dequeue port. A flush input empties the queue in one cycle on a branch redirect. Storage is a circular buffer of DEPTH entries with registered pointers and occupancy count.

---
 rtl/fetch_queue.sv | 75 +++++++
 tb/tb_fetch_queue.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: in-order (pc, instruction) buffer between fetch and decode.
// It has valid/ready handshakes on both ports and a one-cycle flush for branch redirects.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enq_valid_i,
    output logic                     enq_ready_o,
    input  logic [XLEN-1:0]          enq_pc_i,
    input  logic [XLEN-1:0]          enq_instr_i,
    output logic                     deq_valid_o,
    input  logic                     deq_ready_i,
    output logic [XLEN-1:0]          deq_pc_o,
    output logic [XLEN-1:0]          deq_instr_o,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_pc_mem    [DEPTH];
    logic [XLEN-1:0] r_instr_mem [DEPTH];
    logic            r_overflow;
    logic            w_enq_fire;
    logic            w_deq_fire;

    // Ready and valid come only from the registered count, so no comb path crosses the queue.
    assign enq_ready_o = r_count != CW'(DEPTH);
    assign deq_valid_o = r_count != '0;
    assign w_enq_fire  = enq_valid_i & enq_ready_o & ~flush_i;
    assign w_deq_fire  = deq_valid_o & deq_ready_i & ~flush_i;
    assign deq_pc_o    = r_pc_mem[r_rd_ptr];
    assign deq_instr_o = r_instr_mem[r_rd_ptr];
    assign count_o     = r_count;
    assign overflow_o  = r_overflow;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]    <= '0;
                r_instr_mem[i] <= '0;
            end
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq_fire) begin
                r_pc_mem[r_wr_ptr]    <= enq_pc_i;
                r_instr_mem[r_wr_ptr] <= enq_instr_i;
                r_wr_ptr              <= r_wr_ptr + AW'(1);
            end
            if (w_deq_fire)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_enq_fire) - CW'(w_deq_fire);
        end
    end

    // Sticky until reset; a flush does not clear it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_overflow <= 1'b0;
        else if (enq_valid_i & ~enq_ready_o & ~flush_i)
            r_overflow <= 1'b1;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus for fetch_queue, checked every cycle against a queue-based model.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            enq_valid_i = 1'b0;
    logic            enq_ready_o;
    logic [XLEN-1:0] enq_pc_i = '0;
    logic [XLEN-1:0] enq_instr_i = '0;
    logic            deq_valid_o;
    logic            deq_ready_i = 1'b0;
    logic [XLEN-1:0] deq_pc_o;
    logic [XLEN-1:0] deq_instr_o;
    logic            flush_i = 1'b0;
    logic [2:0]      count_o;
    logic            overflow_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } pair_t;
    pair_t m_q[$];
    logic  m_ovf = 1'b0;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .reset_n(reset_n),
        .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o),
        .enq_pc_i(enq_pc_i), .enq_instr_i(enq_instr_i),
        .deq_valid_o(deq_valid_o), .deq_ready_i(deq_ready_i),
        .deq_pc_o(deq_pc_o), .deq_instr_o(deq_instr_o),
        .flush_i(flush_i), .count_o(count_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pairs plus a sticky overflow bit.
    always @(posedge clk or negedge reset_n) begin
        int n;
        if (!reset_n) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else if (flush_i) begin
            m_q.delete();
        end else begin
            n = m_q.size();
            if (enq_valid_i && n == DEPTH) m_ovf = 1'b1;
            if (deq_ready_i && n > 0) void'(m_q.pop_front());
            if (enq_valid_i && n < DEPTH) m_q.push_back('{enq_pc_i, enq_instr_i});
        end
    end

    always @(negedge clk) begin
        check("m_enq_ready", 64'(enq_ready_o), 64'(m_q.size() != DEPTH));
        check("m_deq_valid", 64'(deq_valid_o), 64'(m_q.size() != 0));
        check("m_count", 64'(count_o), 64'(m_q.size()));
        check("m_overflow", 64'(overflow_o), 64'(m_ovf));
        if (m_q.size() > 0) begin
            check("m_deq_pc", 64'(deq_pc_o), 64'(m_q[0].pc));
            check("m_deq_instr", 64'(deq_instr_o), 64'(m_q[0].instr));
        end else if (!reset_n) begin
            check("m_rst_pc", 64'(deq_pc_o), 64'h0);
            check("m_rst_instr", 64'(deq_instr_o), 64'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] instr);
        enq_valid_i = 1'b1;
        enq_pc_i    = pc;
        enq_instr_i = instr;
        tick();
        enq_valid_i = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        reset_n = 1'b1;
        check("rst_enq_ready", 64'(enq_ready_o), 64'h1);
        check("rst_deq_valid", 64'(deq_valid_o), 64'h0);
        check("rst_count", 64'(count_o), 64'h0);
        check("rst_deq_pc", 64'(deq_pc_o), 64'h0);
        check("rst_overflow", 64'(overflow_o), 64'h0);

        for (int k = 0; k < 4; k++) push(32'(4 * k), 32'(8'h11 * (k + 1)));
        check("full_count", 64'(count_o), 64'h4);
        check("full_enq_ready", 64'(enq_ready_o), 64'h0);
        deq_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("drain_pc", 64'(deq_pc_o), 64'(4 * k));
            check("drain_instr", 64'(deq_instr_o), 64'(8'h11 * (k + 1)));
            tick();
        end
        check("drain_count", 64'(count_o), 64'h0);
        check("drain_deq_valid", 64'(deq_valid_o), 64'h0);

        enq_valid_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            enq_pc_i    = 32'(32'h100 + 4 * k);
            enq_instr_i = ~enq_pc_i;
            if (k > 0) check("stream_pc", 64'(deq_pc_o), 64'(32'h100 + 4 * (k - 1)));
            tick();
            check("stream_count", 64'(count_o), 64'h1);
        end
        enq_valid_i = 1'b0;
        check("stream_last_pc", 64'(deq_pc_o), 64'h124);
        tick();
        check("stream_end_count", 64'(count_o), 64'h0);
        deq_ready_i = 1'b0;

        for (int k = 0; k < 4; k++) push(32'(32'h500 + 4 * k), 32'(k));
        enq_valid_i = 1'b1;
        enq_pc_i    = 32'h200;
        enq_instr_i = 32'hdead;
        deq_ready_i = 1'b1;
        tick();
        enq_valid_i = 1'b0;
        deq_ready_i = 1'b0;
        check("ovf_flag", 64'(overflow_o), 64'h1);
        check("ovf_count", 64'(count_o), 64'h3);
        check("ovf_head", 64'(deq_pc_o), 64'h504);
        tick();
        check("ovf_enq_ready", 64'(enq_ready_o), 64'h1);
        deq_ready_i = 1'b1;
        repeat (3) tick();
        deq_ready_i = 1'b0;
        check("ovf_drain_count", 64'(count_o), 64'h0);

        for (int k = 0; k < 3; k++) push(32'(32'h30 + 4 * k), 32'(k + 7));
        flush_i     = 1'b1;
        enq_valid_i = 1'b1;
        enq_pc_i    = 32'h300;
        deq_ready_i = 1'b1;
        tick();
        flush_i     = 1'b0;
        enq_valid_i = 1'b0;
        deq_ready_i = 1'b0;
        check("flush_count", 64'(count_o), 64'h0);
        check("flush_deq_valid", 64'(deq_valid_o), 64'h0);
        check("flush_ovf_kept", 64'(overflow_o), 64'h1);
        push(32'h400, 32'h4444);
        check("post_flush_valid", 64'(deq_valid_o), 64'h1);
        check("post_flush_pc", 64'(deq_pc_o), 64'h400);
        check("post_flush_instr", 64'(deq_instr_o), 64'h4444);
        deq_ready_i = 1'b1;
        tick();
        deq_ready_i = 1'b0;

        push(32'h600, 32'h1);
        push(32'h604, 32'h2);
        check("pre_arst_count", 64'(count_o), 64'h2);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_count", 64'(count_o), 64'h0);
        check("arst_deq_valid", 64'(deq_valid_o), 64'h0);
        check("arst_overflow", 64'(overflow_o), 64'h0);
        check("arst_deq_pc", 64'(deq_pc_o), 64'h0);
        #3;
        reset_n = 1'b1;
        tick();
        check("post_arst_count", 64'(count_o), 64'h0);
        push(32'h700, 32'h77);
        check("post_arst_pc", 64'(deq_pc_o), 64'h700);
        deq_ready_i = 1'b1;
        tick();
        deq_ready_i = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
